alu_issue_arbiter: RTL and testbench

// Shares the single ALU pipe between NREQ issue requesters, such as issue-queue slots or replay ports.
// It picks one valid requester per cycle using a rotating round-robin priority.
// The winner's uop and operands are captured in an output register that drives the master side of alu_issue_if.
// The arbiter honours the downstream stall and flush in the same way as the ALU stage's input register.
//

---
 rtl/alu_issue_arbiter.sv | 117 +++++++++++
 tb/tb_alu_issue_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_arbiter.sv
// Round-robin arbiter sharing the ALU pipe among NREQ issue requesters.
// The winner is captured in an output register that follows the ALU stage's stall/flush rules.
module alu_issue_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ),
    parameter int unsigned UOPW = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            i_req_valid,
    input  logic [NREQ-1:0][UOPW-1:0]  i_req_uop,
    input  logic [NREQ-1:0][31:0]      i_req_op1,
    input  logic [NREQ-1:0][31:0]      i_req_op2,
    output logic [NREQ-1:0]            o_req_ready,
    input  logic                       i_stall,
    input  logic                       i_flush,
    output logic                       o_valid,
    output logic [UOPW-1:0]            o_uop,
    output logic [31:0]                o_op1,
    output logic [31:0]                o_op2,
    output logic [IDW-1:0]             o_grant_id
);

    logic            valid_q, valid_d;
    logic [UOPW-1:0] uop_q, uop_d;
    logic [31:0]     op1_q, op1_d;
    logic [31:0]     op2_q, op2_d;
    logic [IDW-1:0]  grant_id_q, grant_id_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;

    logic            load_en;
    logic            win_found;
    logic [IDW-1:0]  win_id;
    int unsigned     scan_idx;

    assign load_en = (!i_stall || !valid_q) && !i_flush;

    // Scan from rr_ptr upward, wrapping by subtraction instead of a modulo.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = 32'(rr_ptr_q) + k;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            if (!win_found && i_req_valid[IDW'(scan_idx)]) begin
                win_found = 1'b1;
                win_id    = IDW'(scan_idx);
            end
        end
    end

    // Ready is gated by rst_n so nothing looks accepted while reset is held.
    always_comb begin
        o_req_ready = '0;
        if (rst_n && load_en && win_found) begin
            o_req_ready[win_id] = 1'b1;
        end
    end

    always_comb begin
        valid_d    = valid_q;
        uop_d      = uop_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        if (i_flush) begin
            valid_d = 1'b0;
            uop_d   = '0;
            op1_d   = '0;
            op2_d   = '0;
        end else if (load_en) begin
            if (win_found) begin
                valid_d    = 1'b1;
                uop_d      = i_req_uop[win_id];
                op1_d      = i_req_op1[win_id];
                op2_d      = i_req_op2[win_id];
                grant_id_d = win_id;
                if (win_id == IDW'(NREQ - 1)) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = IDW'(win_id + 1'b1);
                end
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            uop_q      <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            valid_q    <= valid_d;
            uop_q      <= uop_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign o_valid    = valid_q;
    assign o_uop      = uop_q;
    assign o_op1      = op1_q;
    assign o_op2      = op2_q;
    assign o_grant_id = grant_id_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Randomized bench for alu_issue_arbiter against a queue-free behavioural model of
// round-robin selection, the stall/flush-aware output register and requester hand-off.
module tb_alu_issue_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;
    localparam int unsigned UOPW = 32;

    logic                      clk;
    logic                      rst_n;
    logic [NREQ-1:0]           i_req_valid;
    logic [NREQ-1:0][UOPW-1:0] i_req_uop;
    logic [NREQ-1:0][31:0]     i_req_op1;
    logic [NREQ-1:0][31:0]     i_req_op2;
    logic [NREQ-1:0]           o_req_ready;
    logic                      i_stall;
    logic                      i_flush;
    logic                      o_valid;
    logic [UOPW-1:0]           o_uop;
    logic [31:0]               o_op1;
    logic [31:0]               o_op2;
    logic [IDW-1:0]            o_grant_id;

    alu_issue_arbiter #(.NREQ(NREQ), .IDW(IDW), .UOPW(UOPW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_valid (i_req_valid),
        .i_req_uop   (i_req_uop),
        .i_req_op1   (i_req_op1),
        .i_req_op2   (i_req_op2),
        .o_req_ready (o_req_ready),
        .i_stall     (i_stall),
        .i_flush     (i_flush),
        .o_valid     (o_valid),
        .o_uop       (o_uop),
        .o_op1       (o_op1),
        .o_op2       (o_op2),
        .o_grant_id  (o_grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference state: what the output register should hold and where priority starts.
    bit          m_valid;
    bit          m_known;
    logic [31:0] m_uop, m_op1, m_op2;
    int          m_gid;
    int          m_ptr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int find_win();
        for (int k = 0; k < int'(NREQ); k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (i_req_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [31:0] op1);
        i_req_valid[i] = 1'b1;
        i_req_uop[i]   = $urandom;
        i_req_op1[i]   = op1;
        i_req_op2[i]   = $urandom;
    endtask

    task automatic refill(input int pct);
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!i_req_valid[i] && $urandom_range(99) < pct) set_req(i, $urandom);
        end
    endtask

    task automatic check_outputs();
        check("o_valid", o_valid, m_valid);
        if (m_valid || m_known) begin
            check("o_uop", o_uop, m_uop);
            check("o_op1", o_op1, m_op1);
            check("o_op2", o_op2, m_op2);
        end
        if (m_valid) check("o_grant_id", o_grant_id, m_gid);
    endtask

    // Asserted off the clock edge so it also exercises the asynchronous path.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        m_valid = 0; m_known = 1; m_uop = '0; m_op1 = '0; m_op2 = '0;
        m_gid = 0; m_ptr = 0;
        check("rst_ready", o_req_ready, '0);
        check("rst_gid", o_grant_id, 0);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input bit stall, input bit flush);
        int              w;
        bit              load_en;
        logic [NREQ-1:0] exp_rdy;
        i_stall = stall;
        i_flush = flush;
        #1;
        w       = find_win();
        load_en = (!stall || !m_valid) && !flush;
        exp_rdy = '0;
        if (load_en && w >= 0) exp_rdy[w] = 1'b1;
        check("ready", o_req_ready, exp_rdy);
        @(posedge clk);
        #1;
        if (flush) begin
            m_valid = 0; m_known = 1; m_uop = '0; m_op1 = '0; m_op2 = '0;
        end else if (load_en) begin
            if (w >= 0) begin
                m_valid = 1; m_known = 1;
                m_uop = i_req_uop[w]; m_op1 = i_req_op1[w]; m_op2 = i_req_op2[w];
                m_gid = w;
                m_ptr = (w + 1) % NREQ;
                i_req_valid[w] = 1'b0;
            end else begin
                m_valid = 0; m_known = 0;
            end
        end
        check_outputs();
    endtask

    initial begin
        rst_n = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
        i_req_valid = '0; i_req_uop = '0; i_req_op1 = '0; i_req_op2 = '0;

        // Reset with every requester valid, then the first grant goes to req0.
        refill(100);
        do_reset();
        step(0, 0);
        check("first_gid", o_grant_id, 0);

        // Fairness with all requesters held valid.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            refill(100);
            step(0, 0);
            check("fair_gid", o_grant_id, k % NREQ);
            check("fair_valid", o_valid, 1);
        end

        // Stall holds a full register; release resumes at ptr=3.
        i_req_valid = '0;
        do_reset();
        set_req(2, 32'h1234_5678);
        step(0, 0);
        refill(100);
        for (int k = 0; k < 3; k++) begin
            step(1, 0);
            check("stall_op1", o_op1, 32'h1234_5678);
        end
        step(0, 0);
        check("stall_next", o_grant_id, 3);

        // Empty register fills during a stall.
        i_req_valid = '0;
        do_reset();
        set_req(1, 32'hDEAD_BEEF);
        step(1, 0);
        check("fill_op1", o_op1, 32'hDEAD_BEEF);

        // Flush clears the register and leaves the pointer wrapped to 0.
        i_req_valid = '0;
        do_reset();
        set_req(3, $urandom);
        step(0, 0);
        set_req(0, $urandom);
        set_req(1, $urandom);
        step(0, 1);
        check("flush_uop", o_uop, 0);
        step(0, 0);
        check("flush_next", o_grant_id, 0);

        // Sparse single requester with bubbles between grants.
        i_req_valid = '0;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) set_req(3, $urandom);
            step(0, 0);
        end

        // Random traffic with occasional mid-run asynchronous resets.
        for (int k = 0; k < 600; k++) begin
            refill(40);
            step(($urandom % 4) == 0, ($urandom % 20) == 0);
            if (k % 150 == 149) do_reset();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
